// File: rtl/reg_file_param_if.sv
// Bundle of read/write port signals between decode/writeback and the register bank.
// The bank side uses the slave modport; the requester side uses master.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] dato_a;
  logic [DATA_W-1:0] dato_b;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              wr_err;

  modport master (
    output rd_en, rs, rt, wr_en, wr_addr, wr_data,
    input  dato_a, dato_b, rd_valid, busy, wr_err
  );

  modport slave (
    input  rd_en, rs, rt, wr_en, wr_addr, wr_data,
    output dato_a, dato_b, rd_valid, busy, wr_err
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register bank: two registered read ports, one write port, optional $zero
// and write-to-read bypass, with a post-reset sequencer that clears storage one entry per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing mem[init_ptr]; port requests ignored, busy=1
// ST_RUN  | normal read/write service
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_param_if.slave  bus
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic            HAS_ZERO = (ZERO_REG != 0);
  localparam logic            HAS_BYP  = (BYPASS != 0);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0] dato_a_q, dato_a_d;
  logic [DATA_W-1:0] dato_b_q, dato_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_ok;
  logic              wr_bad;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return HAS_ZERO && (a == '0);
  endfunction

  // Out-of-range and hardwired-zero reads return 0; bypass only from a write that will land.
  function automatic logic [DATA_W-1:0] port_val(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              w_ok,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data
  );
    if (!in_range(a) || is_zero_reg(a)) return '0;
    if (HAS_BYP && w_ok && (w_addr == a)) return w_data;
    return stored;
  endfunction

  assign wr_ok  = bus.wr_en && in_range(bus.wr_addr) && !is_zero_reg(bus.wr_addr);
  assign wr_bad = bus.wr_en && !in_range(bus.wr_addr);
  assign mem_a  = mem[bus.rs[IDX_W-1:0]];
  assign mem_b  = mem[bus.rt[IDX_W-1:0]];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    rd_valid_d = 1'b0;
    wr_err_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = init_ptr_q[IDX_W-1:0];
    mem_wdata  = '0;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        init_ptr_d = init_ptr_q + (ADDR_W+1)'(1);
        wr_err_d   = bus.wr_en;
        if (init_ptr_q == LAST_C) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.rd_en) begin
          dato_a_d   = port_val(bus.rs, mem_a, wr_ok, bus.wr_addr, bus.wr_data);
          dato_b_d   = port_val(bus.rt, mem_b, wr_ok, bus.wr_addr, bus.wr_data);
          rd_valid_d = 1'b1;
        end
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr[IDX_W-1:0];
          mem_wdata = bus.wr_data;
        end
        wr_err_d = wr_bad;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Storage has no reset so it can map onto a RAM macro; the INIT sequence clears it.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dato_a   = dato_a_q;
  assign bus.dato_b   = dato_b_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three instances (default, no-zero/no-bypass, DEPTH=16)
// driven in lockstep against a behavioural model with a read-result scoreboard.
module tb_reg_file_param;

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [4:0]  rs, rt, wr_addr;
  logic [31:0] wr_data;

  logic [31:0] o_a [3];
  logic [31:0] o_b [3];
  logic        o_valid [3];
  logic        o_busy [3];
  logic        o_err [3];

  int checks = 0;
  int errors = 0;

  // model state
  int          m_depth [3] = '{32, 32, 16};
  bit          m_zero  [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem   [3][32];
  bit          m_busy  [3];
  int          m_ptr   [3];
  logic [31:0] m_last_a [3];
  logic [31:0] m_last_b [3];
  bit          m_valid [3];
  bit          m_err   [3];
  exp_t        sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    assign bus.rd_en   = rd_en;
    assign bus.rs      = rs;
    assign bus.rt      = rt;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign o_a[g]      = bus.dato_a;
    assign o_b[g]      = bus.dato_b;
    assign o_valid[g]  = bus.rd_valid;
    assign o_busy[g]   = bus.busy;
    assign o_err[g]    = bus.wr_err;
    reg_file_param #(
      .DATA_W(32), .ADDR_W(5),
      .DEPTH((g == 2) ? 16 : 32),
      .ZERO_REG((g == 1) ? 0 : 1),
      .BYPASS((g == 1) ? 0 : 1)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
  end

  function automatic logic [31:0] model_read(int i, logic [4:0] a, logic wok);
    if (int'(a) >= m_depth[i] || (m_zero[i] && a == 5'd0)) return 32'h0;
    if (m_byp[i] && wok && wr_addr == a) return wr_data;
    return m_mem[i][a];
  endfunction

  // One clock: model follows the edge using the inputs sampled there; outputs settle by #1.
  task automatic step();
    exp_t e;
    logic wok;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_err[i]   = 1'b0;
      if (reset) begin
        m_busy[i] = 1'b1; m_ptr[i] = 0; m_last_a[i] = '0; m_last_b[i] = '0;
      end else if (m_busy[i]) begin
        m_mem[i][m_ptr[i]] = '0;
        m_ptr[i]++;
        if (m_ptr[i] == m_depth[i]) m_busy[i] = 1'b0;
        m_err[i] = wr_en;
      end else begin
        wok = wr_en && (int'(wr_addr) < m_depth[i]) && !(m_zero[i] && wr_addr == 5'd0);
        if (rd_en) begin
          e.inst = i;
          e.a = model_read(i, rs, wok);
          e.b = model_read(i, rt, wok);
          sb.push_back(e);
          m_last_a[i] = e.a; m_last_b[i] = e.b; m_valid[i] = 1'b1;
        end
        if (wok) m_mem[i][wr_addr] = wr_data;
        m_err[i] = wr_en && (int'(wr_addr) >= m_depth[i]);
      end
    end
    #1;
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; rs = 0; rt = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_a[i] !== 32'h0 || o_b[i] !== 32'h0 || o_valid[i] !== 1'b0 ||
          o_err[i] !== 1'b0 || o_busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst%0d got a=%h b=%h v=%b e=%b busy=%b exp 0/0/0/0/1",
                 i, o_a[i], o_b[i], o_valid[i], o_err[i], o_busy[i]);
      end
    end
  endtask

  task automatic test_init();
    int cnt [3] = '{0, 0, 0};
    exp_t e;
    reset = 0; idle();
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) if (o_busy[i]) cnt[i]++;
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_valid[i] !== m_valid[i] || o_err[i] !== m_err[i]) begin
          errors++;
          $display("FAIL init_flags inst%0d got v=%b e=%b exp v=%b e=%b",
                   i, o_valid[i], o_err[i], m_valid[i], m_err[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== ((i == 2) ? 16 : 32)) begin
        errors++;
        $display("FAIL busy_len inst%0d got %0d exp %0d", i, cnt[i], (i == 2) ? 16 : 32);
      end
    end
    rd_en = 1; rs = 5'd8; rt = 5'd31;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid[i] !== 1'b1 || o_a[i] !== 32'h0 || o_b[i] !== 32'h0) begin
        errors++;
        $display("FAIL init_zero inst%0d got v=%b a=%h b=%h exp 1/0/0", i, o_valid[i], o_a[i], o_b[i]);
      end
      if (m_valid[i]) begin
        e = sb.pop_front();
        checks++;
        if (o_a[i] !== e.a || o_b[i] !== e.b) begin
          errors++;
          $display("FAIL init_sb inst%0d got %h/%h exp %h/%h", i, o_a[i], o_b[i], e.a, e.b);
        end
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    wr_en = 1; wr_addr = 5'd9;  wr_data = 32'hDEADBEEF; step();
    wr_en = 1; wr_addr = 5'd13; wr_data = 32'h12345678; step();
    idle(); rd_en = 1; rs = 5'd9; rt = 5'd13;
    for (int k = 0; k < 3; k++) begin
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_valid[i] !== m_valid[i] || o_err[i] !== m_err[i] ||
            o_a[i] !== m_last_a[i] || o_b[i] !== m_last_b[i]) begin
          errors++;
          $display("FAIL wr_rd inst%0d step%0d got v=%b e=%b %h/%h exp v=%b e=%b %h/%h",
                   i, k, o_valid[i], o_err[i], o_a[i], o_b[i], m_valid[i], m_err[i], m_last_a[i], m_last_b[i]);
        end
        if (m_valid[i]) begin
          e = sb.pop_front();
          checks++;
          if (o_a[i] !== 32'hDEADBEEF || o_b[i] !== 32'h12345678 || e.a !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_data inst%0d got %h/%h exp deadbeef/12345678", i, o_a[i], o_b[i]);
          end
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      idle(); rd_en = 1; rs = 5'd10; rt = 5'd10;
      if (k == 0) begin wr_en = 1; wr_addr = 5'd10; wr_data = 32'hA5A5A5A5; end
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
        want = (k == 0 && i == 1) ? 32'h0 : 32'hA5A5A5A5;
        checks++;
        if (o_valid[i] !== 1'b1 || o_a[i] !== want || o_b[i] !== want) begin
          errors++;
          $display("FAIL bypass inst%0d pass%0d got v=%b %h/%h exp %h", i, k, o_valid[i], o_a[i], o_b[i], want);
        end
        if (m_valid[i]) begin
          e = sb.pop_front();
          checks++;
          if (o_a[i] !== e.a || o_b[i] !== e.b) begin
            errors++;
            $display("FAIL bypass_sb inst%0d got %h/%h exp %h/%h", i, o_a[i], o_b[i], e.a, e.b);
          end
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      idle(); rd_en = 1; rs = 5'd0; rt = (k == 0) ? 5'd0 : 5'd9;
      if (k == 0) begin wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; end
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
        want = (k == 1 && i == 1) ? 32'hFFFFFFFF : 32'h0;
        checks++;
        if (o_err[i] !== 1'b0 || o_a[i] !== want) begin
          errors++;
          $display("FAIL zero_reg inst%0d pass%0d got e=%b a=%h exp e=0 a=%h", i, k, o_err[i], o_a[i], want);
        end
        if (m_valid[i]) begin
          e = sb.pop_front();
          checks++;
          if (o_a[i] !== e.a || o_b[i] !== e.b) begin
            errors++;
            $display("FAIL zero_sb inst%0d got %h/%h exp %h/%h", i, o_a[i], o_b[i], e.a, e.b);
          end
        end
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    // write 20, idle, write 20, write 31, idle, read 20/31
    logic [4:0]  addr_t [6] = '{5'd20, 5'd0, 5'd20, 5'd31, 5'd0, 5'd0};
    logic [31:0] data_t [6] = '{32'h77, 32'h0, 32'h55, 32'h66, 32'h0, 32'h0};
    bit          wen_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      idle();
      wr_en = wen_t[k]; wr_addr = addr_t[k]; wr_data = data_t[k];
      if (k == 5) begin rd_en = 1; rs = 5'd20; rt = 5'd31; end
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_err[i] !== ((i == 2) && wen_t[k])) begin
          errors++;
          $display("FAIL wr_err inst%0d step%0d got %b exp %b", i, k, o_err[i], (i == 2) && wen_t[k]);
        end
        if (m_valid[i]) begin
          e = sb.pop_front();
          checks++;
          if (o_a[i] !== e.a || o_b[i] !== e.b ||
              o_a[i] !== ((i == 2) ? 32'h0 : 32'h55) || o_b[i] !== ((i == 2) ? 32'h0 : 32'h66)) begin
            errors++;
            $display("FAIL range_rd inst%0d got %h/%h exp %h/%h", i, o_a[i], o_b[i], e.a, e.b);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cnt [3] = '{0, 0, 0};
    exp_t e;
    idle(); wr_en = 1; wr_addr = 5'd12; wr_data = 32'h11111111; step();
    idle(); rd_en = 1; rs = 5'd12; reset = 1; step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_a[i] !== 32'h0 || o_busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset inst%0d got v=%b a=%h busy=%b exp 0/0/1", i, o_valid[i], o_a[i], o_busy[i]);
      end
    end
    reset = 0; idle();
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) if (o_busy[i]) cnt[i]++;
      if (k == 3) begin wr_en = 1; wr_addr = 5'd5; wr_data = 32'hBAD; end
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_err[i] !== (k == 3) || o_valid[i] !== 1'b0) begin
          errors++;
          $display("FAIL busy_wr inst%0d step%0d got e=%b v=%b exp e=%b v=0", i, k, o_err[i], o_valid[i], k == 3);
        end
      end
    end
    rd_en = 1; rs = 5'd12; rt = 5'd5;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== ((i == 2) ? 16 : 32) || o_valid[i] !== 1'b1 || o_a[i] !== 32'h0 || o_b[i] !== 32'h0) begin
        errors++;
        $display("FAIL reinit inst%0d got busy_len=%0d v=%b %h/%h exp %0d 1 0/0",
                 i, cnt[i], o_valid[i], o_a[i], o_b[i], (i == 2) ? 16 : 32);
      end
      if (m_valid[i]) begin
        e = sb.pop_front();
        checks++;
        if (o_a[i] !== e.a || o_b[i] !== e.b) begin
          errors++;
          $display("FAIL reinit_sb inst%0d got %h/%h exp %h/%h", i, o_a[i], o_b[i], e.a, e.b);
        end
      end
    end
  endtask

  initial begin
    reset = 1; idle();
    test_reset();
    test_init();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_errors();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain leftover %0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
